ecd_request_arbiter: RTL
========================

# ecd_request_arbiter

Shares the single 256-bit ECD request stream among NUM_REQ independent request sources, such as request generators and test sources. It grants sources round-robin and holds each granted request in a registered output stage. It also enforces a global credit window that caps unfulfilled row requests at MAX_OUTSTANDING, using ROW_COMPLETE pulses from the ECD master as credit returns. The block sits between the request generators and the ECD_Master request input.

## Interface
- NUM_REQ, 4: number of requester ports, 2..8
- DATA_W, 256: request word width
- MAX_OUTSTANDING, 8: credit window, 1..255
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- S_TDATA  in  NUM_REQ*DATA_W  requester payloads; port i occupies bits [i*DATA_W +: DATA_W]
- S_TVALID  in  NUM_REQ  per-requester valid
- S_TREADY  out  NUM_REQ  per-requester ready, one-hot or zero
- M_TDATA  out  DATA_W  request to ECD master, registered
- M_TVALID  out  1  output valid, registered
- M_TLAST  out  1  equals M_TVALID; every request is a single beat
- M_TREADY  in  1  downstream ready
- ROW_COMPLETE  in  1  one-cycle pulse per fulfilled request (credit return)
- ENABLE  in  1  level; 0 blocks new grants
- OUTSTANDING  out  8  requests granted but not yet completed, registered
- LAST_GRANT  out  3  index of the most recently granted requester
- CREDIT_ERR  out  1  sticky; set by ROW_COMPLETE while OUTSTANDING==0

## Operation
- Output stage is free when M_TVALID==0, or when M_TVALID==1 and M_TREADY==1.
- can_grant = ENABLE & free & (OUTSTANDING < MAX_OUTSTANDING) & |S_TVALID.
- Selection: the first i with S_TVALID[i]==1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
- On can_grant with selected index g:
  - S_TREADY[g]=1 combinationally in the same cycle;
  - next cycle: M_TDATA <= S_TDATA[g], M_TVALID <= 1, LAST_GRANT <= g, rr_ptr <= (g+1) mod NUM_REQ.
- A free stage with no grant clears M_TVALID. M_TDATA holds its last value.
- Credit update (registered):
  - OUTSTANDING <= OUTSTANDING + grant - ROW_COMPLETE.
  - Grant and ROW_COMPLETE in the same cycle leave it unchanged.
  - ROW_COMPLETE with OUTSTANDING==0 leaves it at 0 and sets CREDIT_ERR.
- A credit returned in cycle N is usable for a grant in cycle N+1, not cycle N.
- ENABLE=0: no new grants. A request already in the output stage is still delivered. ROW_COMPLETE is still counted.
- S_TREADY never asserts for an index whose S_TVALID is 0.

## Timing
- Reset values: M_TVALID=0, M_TLAST=0, M_TDATA=0, S_TREADY=0, OUTSTANDING=0, LAST_GRANT=0, CREDIT_ERR=0, rr_ptr=0.
- Latency: one cycle from S handshake to M_TVALID.
- Throughput: 1 request per cycle while M_TREADY=1 and credits remain.
- M_TVALID/M_TDATA are stable until accepted and never drop without a handshake.
- Full window (OUTSTANDING==MAX_OUTSTANDING): S_TREADY is all zero. The held output still drains.
- Reset mid-operation: the held request is discarded and all state returns to reset values on the next edge. CREDIT_ERR clears only on reset.

## Structure
- Package ecd_req_pkg: ECD_REQ_W=256, ECD_ROW_CMD base value 32'h0000_C008, default credit window 8, requester index width.
- Sub-module ecd_rr_select:
  - combinational round-robin priority selection: inputs request vector and rr_ptr; outputs one-hot grant, grant index, any;
  - the pointer register stays in the parent.

## Test plan
- Single requester 0 sends 3 words C008, C009, C00A; M_TREADY=1; no completions. Expect 3 outputs on consecutive cycles, each arriving 1 cycle after its handshake. OUTSTANDING ends at 3 and M_TLAST=1 on every beat.
- All 4 requesters continuously valid, MAX_OUTSTANDING=8, ROW_COMPLETE every cycle after the first grant. Expect grant order 0,1,2,3,0,1,2,3; LAST_GRANT follows that order; no requester is starved.
- Credit limit: requester 1 valid, no ROW_COMPLETE. Expect exactly 8 grants, then S_TREADY=0. One ROW_COMPLETE pulse must produce exactly one further grant, on the cycle after the pulse.
- Backpressure: M_TREADY=0 for 10 cycles with a request held. Expect M_TDATA and M_TVALID stable throughout and no further grants. After M_TREADY=1, expect delivery and resumed flow.
- Simultaneous grant and ROW_COMPLETE with OUTSTANDING=5 → OUTSTANDING stays 5. ROW_COMPLETE with OUTSTANDING=0 → OUTSTANDING stays 0 and CREDIT_ERR=1 until reset.
- ENABLE dropped while a request is held and resetn asserted mid-stream:
  - with ENABLE low, the held request still delivers and no new grant occurs;
  - after reset, all outputs are at reset values and the first grant goes to requester 0.

Source files
------------

// File: rtl/ecd_req_pkg.sv
// Shared types and constants for the ECD request path: widths, the row-command
// base value and the credit window default.
package ecd_req_pkg;

  localparam int unsigned ECD_REQ_W               = 256;
  localparam logic [31:0] ECD_ROW_CMD             = 32'h0000_C008;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 8;
  localparam int unsigned REQ_IDX_W               = 3;
  localparam int unsigned CREDIT_W                = 8;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  typedef logic [CREDIT_W-1:0]  credit_t;

  // Index following idx in a ring of num_req requesters.
  function automatic req_idx_t rr_next(input req_idx_t idx, input int unsigned num_req);
    return ((32'(idx) + 32'd1) >= num_req) ? '0 : req_idx_t'(idx + req_idx_t'(1));
  endfunction

endpackage

// File: rtl/ecd_rr_select.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module ecd_rr_select
  import ecd_req_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output req_idx_t           gnt_idx,
  output logic               any
);

  // Outer loop walks priority order; inner loop keeps every bit select constant.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (((32'(rr_ptr) + k) % NUM_REQ) == i)) begin
          any       = 1'b1;
          gnt_idx   = req_idx_t'(i);
          gnt_oh[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ecd_request_arbiter.sv
// Round-robin arbiter sharing the ECD request stream among NUM_REQ sources,
// with a registered output stage and a global outstanding-request credit window.
module ecd_request_arbiter
  import ecd_req_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_W          = ECD_REQ_W,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ*DATA_W-1:0] S_TDATA,
  input  logic [NUM_REQ-1:0]        S_TVALID,
  output logic [NUM_REQ-1:0]        S_TREADY,
  output logic [DATA_W-1:0]         M_TDATA,
  output logic                      M_TVALID,
  output logic                      M_TLAST,
  input  logic                      M_TREADY,
  input  logic                      ROW_COMPLETE,
  input  logic                      ENABLE,
  output logic [CREDIT_W-1:0]       OUTSTANDING,
  output logic [REQ_IDX_W-1:0]      LAST_GRANT,
  output logic                      CREDIT_ERR
);

  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic               m_tvalid_q, m_tvalid_d;
  req_idx_t           last_grant_q, last_grant_d;
  req_idx_t           rr_ptr_q, rr_ptr_d;
  credit_t            outstanding_q, outstanding_d;
  logic               credit_err_q, credit_err_d;

  logic [NUM_REQ-1:0] sel_oh;
  req_idx_t           sel_idx;
  logic               sel_any;
  logic               free_c;
  logic               credit_ok_c;
  logic               grant_c;

  ecd_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req     (S_TVALID),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (sel_oh),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  // Grant qualification; resetn gates it so no handshake happens during reset.
  always_comb begin
    free_c      = !m_tvalid_q || M_TREADY;
    credit_ok_c = outstanding_q < CREDIT_W'(MAX_OUTSTANDING);
    grant_c     = resetn && ENABLE && free_c && credit_ok_c && sel_any;
    S_TREADY    = grant_c ? sel_oh : '0;
  end

  // Next-state for the output stage, round-robin pointer and credit counter.
  always_comb begin
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q;
    last_grant_d  = last_grant_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    credit_err_d  = credit_err_q;

    if (grant_c) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (sel_idx == req_idx_t'(i)) begin
          m_tdata_d = S_TDATA[i*DATA_W +: DATA_W];
        end
      end
      m_tvalid_d   = 1'b1;
      last_grant_d = sel_idx;
      rr_ptr_d     = rr_next(sel_idx, NUM_REQ);
    end else if (free_c) begin
      m_tvalid_d = 1'b0;
    end

    // A completion with nothing outstanding is a protocol error, never an underflow.
    case ({grant_c, ROW_COMPLETE})
      2'b10:   outstanding_d = outstanding_q + credit_t'(1);
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - credit_t'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (ROW_COMPLETE && (outstanding_q == '0)) begin
      credit_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      last_grant_q  <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      credit_err_q  <= 1'b0;
    end else begin
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      last_grant_q  <= last_grant_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      credit_err_q  <= credit_err_d;
    end
  end

  assign M_TDATA     = m_tdata_q;
  assign M_TVALID    = m_tvalid_q;
  assign M_TLAST     = m_tvalid_q;
  assign OUTSTANDING = outstanding_q;
  assign LAST_GRANT  = last_grant_q;
  assign CREDIT_ERR  = credit_err_q;

endmodule
